// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus UART-style IO window behind a byte-serial memory port with 1-cycle read latency
module mem_io_responder #(
  parameter int ADDR_WIDTH  = 17,
  parameter int TX_DEPTH    = 8,
  parameter int FULL_MARGIN = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        mem_rw,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_overflow
);
  localparam int PW = $clog2(TX_DEPTH);
  logic [7:0] ram [2**ADDR_WIDTH];
  logic [7:0] fifo [TX_DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0] tx_count;
  logic rx_full, tx_full;
  logic [7:0] rx_byte, ram_q, io_q, io_val;
  logic io_sel, io, is_data, is_status, rd, wr, pop, push_req, push, rx_take, capture;
  assign io             = mem_addr[17];
  assign is_data        = io & (mem_addr[2:0] == 3'd0);
  assign is_status      = io & (mem_addr[2:0] == 3'd4);
  assign rd             = rdy & ~mem_rw;
  assign wr             = rdy & mem_rw;
  assign tx_full        = tx_count == (PW+1)'(TX_DEPTH);
  assign tx_valid       = tx_count != '0;
  assign tx_data        = fifo[head];
  assign io_buffer_full = tx_count >= (PW+1)'(TX_DEPTH - FULL_MARGIN);
  assign rx_ready       = ~rx_full;
  assign pop            = tx_valid & tx_ready;
  assign push_req       = wr & is_data;
  assign push           = push_req & (~tx_full | pop);
  assign rx_take        = rd & is_data & rx_full;
  assign capture        = rx_valid & ~rx_full;
  assign mem_dout       = io_sel ? io_q : ram_q;
  always_comb io_val = is_data ? (rx_full ? rx_byte : 8'h00) : is_status ? {6'b0, tx_full, rx_full} : 8'h00;
  always_ff @(posedge clk) begin
    if (wr & ~io) ram[mem_addr[ADDR_WIDTH-1:0]] <= mem_din;
    if (rd & ~io) ram_q <= ram[mem_addr[ADDR_WIDTH-1:0]];
    if (push) fifo[tail] <= mem_din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      io_sel      <= 1'b1;
      io_q        <= 8'h00;
      head        <= '0;
      tail        <= '0;
      tx_count    <= '0;
      rx_full     <= 1'b0;
      rx_byte     <= 8'h00;
      tx_overflow <= 1'b0;
    end else begin
      if (rd) begin
        io_sel <= io;
        io_q   <= io_val;
      end
      if (pop) head <= head + 1'b1;
      if (push) tail <= tail + 1'b1;
      tx_count <= tx_count + (PW+1)'(push) - (PW+1)'(pop);
      if (push_req & ~push) tx_overflow <= 1'b1;
      if (rx_take) rx_full <= 1'b0;
      else if (capture) begin
        rx_full <= 1'b1;
        rx_byte <= rx_data;
      end
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed and randomized accesses checked cycle by cycle
// against a queue/array model of the RAM, TX FIFO and RX holding register.
module tb_mem_io_responder;
    logic        clk = 0, rst = 0, rdy = 0, mem_rw = 0, tx_ready = 0, rx_valid = 0;
    logic [31:0] mem_addr = 0;
    logic [7:0]  mem_din = 0, rx_data = 0;
    logic [7:0]  mem_dout, tx_data;
    logic        io_buffer_full, tx_valid, rx_ready, tx_overflow;

    int passed = 0, total = 0;

    logic [7:0] m_ram [int];
    logic [7:0] m_q [$];
    logic       m_rxf = 0, m_ovf = 0;
    logic [7:0] m_rxb = 0, m_dout = 0;

    mem_io_responder dut (
        .clk(clk), .rst(rst), .rdy(rdy), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .io_buffer_full(io_buffer_full),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .tx_overflow(tx_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // one clock: drive, update the model from the pre-edge state, then compare all outputs
    task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [7:0] d,
                        input logic txr, input logic rxv, input logic [7:0] rxd, input logic rs);
        logic pop, push, clr, cap;
        rst = rs; rdy = r; mem_rw = w; mem_addr = a; mem_din = d;
        tx_ready = txr; rx_valid = rxv; rx_data = rxd;
        @(posedge clk);
        if (rs) begin
            m_dout = 0; m_q.delete(); m_rxf = 0; m_ovf = 0;
        end else begin
            pop = m_q.size() > 0 && txr;
            cap = rxv && !m_rxf;
            push = 0; clr = 0;
            if (r && !w) begin
                if (!a[17]) m_dout = m_ram[int'(a[16:0])];
                else if (a[2:0] == 0) begin m_dout = m_rxf ? m_rxb : 8'h00; clr = m_rxf; end
                else if (a[2:0] == 4) m_dout = {6'b0, m_q.size() == 8, m_rxf};
                else m_dout = 8'h00;
            end
            if (r && w) begin
                if (!a[17]) m_ram[int'(a[16:0])] = d;
                else if (a[2:0] == 0) begin
                    if (m_q.size() < 8 || pop) push = 1;
                    else m_ovf = 1;
                end
            end
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(d);
            if (clr) m_rxf = 0;
            if (cap) begin m_rxf = 1; m_rxb = rxd; end
        end
        #1;
        check("dout", mem_dout, m_dout);
        check("tx_valid", tx_valid, m_q.size() > 0);
        if (m_q.size() > 0) check("tx_data", tx_data, m_q[0]);
        check("buf_full", io_buffer_full, m_q.size() >= 6);
        check("rx_ready", rx_ready, !m_rxf);
        check("overflow", tx_overflow, m_ovf);
    endtask

    task automatic rd_(input logic [31:0] a);  step(1, 0, a, 0, 0, 0, 0, 0); endtask
    task automatic wr_(input logic [31:0] a, input logic [7:0] d); step(1, 1, a, d, 0, 0, 0, 0); endtask
    task automatic reset_(); step(0, 0, 0, 0, 0, 0, 0, 1); step(0, 0, 0, 0, 0, 0, 0, 1); endtask

    initial begin
        logic [31:0] pool [22];
        logic [31:0] a;
        reset_();
        check("rst_dout", mem_dout, 0);
        check("rst_rx_ready", rx_ready, 1);
        check("rst_tx_valid", tx_valid, 0);
        // preload every RAM address the run will read
        for (int i = 0; i < 4; i++) wr_(i, 8'h11 * (i + 1));
        for (int i = 0; i < 16; i++) wr_(32'h200 + i, 8'($urandom));
        wr_(32'h100, 8'h00);
        for (int i = 0; i < 4; i++) pool[i] = i;
        for (int i = 0; i < 16; i++) pool[4 + i] = 32'h200 + i;
        pool[20] = 32'h100; pool[21] = 32'h1FFFF;
        wr_(32'h1FFFF, 8'h3C);

        wr_(32'h100, 8'hA5);
        rd_(32'h100);           check("ram_rw", mem_dout, 8'hA5);
        wr_(32'h0, 8'h11);      check("hold_on_write", mem_dout, 8'hA5);
        rd_(32'h40100);         check("ram_wrap", mem_dout, 8'hA5);
        rd_(32'h20101);         check("io_unmapped", mem_dout, 8'h00);
        rd_(32'h20100);         check("io_data_empty", mem_dout, 8'h00);

        rd_(0); check("lat0", mem_dout, 8'h11);
        rd_(1); check("lat1", mem_dout, 8'h22);
        rd_(2); check("lat2", mem_dout, 8'h33);
        rd_(3); check("lat3", mem_dout, 8'h44);

        for (int i = 0; i < 6; i++) wr_(32'h30000, 8'hC0 + i);
        check("full_at_6", io_buffer_full, 1);
        wr_(32'h30000, 8'hC6); wr_(32'h30000, 8'hC7);
        rd_(32'h30004);         check("status_txfull", mem_dout, 8'h02);
        wr_(32'h30000, 8'hEE);  check("overflow_set", tx_overflow, 1);
        for (int i = 0; i < 8; i++) begin
            check("drain_order", tx_data, 8'hC0 + i);
            step(1, 0, 0, 0, 1, 0, 0, 0);
        end
        check("drained", tx_valid, 0);

        reset_();
        for (int i = 0; i < 8; i++) wr_(32'h30000, 8'(i));
        step(1, 1, 32'h30000, 8'h99, 1, 0, 0, 0);
        check("pushpop_ovf", tx_overflow, 0);
        check("pushpop_head", tx_data, 8'h01);

        reset_();
        step(1, 0, 0, 0, 0, 1, 8'h5A, 0); check("rx_captured", rx_ready, 0);
        rd_(32'h30004);         check("status_rx", mem_dout, 8'h01);
        rd_(32'h30000);         check("rx_data", mem_dout, 8'h5A);
        check("rx_freed", rx_ready, 1);
        rd_(32'h30000);         check("rx_empty", mem_dout, 8'h00);

        step(0, 1, 32'h100, 8'h77, 0, 0, 0, 0);
        rd_(32'h100);           check("rdy0_write", mem_dout, 8'hA5);

        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0: a = 32'h30000;
                1: a = 32'h30004 | ($urandom_range(0, 4) == 0 ? 32'h1 : 32'h0);
                default: a = ({$urandom} & 32'hFFFC_0000) | pool[$urandom_range(0, 21)];
            endcase
            step($urandom_range(0, 9) != 0, $urandom_range(0, 1), a, 8'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1), 8'($urandom),
                 $urandom_range(0, 99) == 0);
        end

        rd_(0); rd_(1);
        step(1, 0, 2, 0, 0, 0, 0, 1);
        check("rst_burst_dout", mem_dout, 0);
        check("rst_burst_ovf", tx_overflow, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
